// File: rtl/control_fsm_pkg.sv
// Shared encodings for the multi-cycle control FSM: states, opcode (inst[6:2]) values,
// datapath select encodings and the decoded control bundle.
package control_fsm_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_MULDIV = 3'd5,
        ST_FAULT  = 3'd7
    } state_t;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_JAL  = 2'b01;
    localparam logic [1:0] JMP_JALR = 2'b10;

    localparam logic [2:0] WB_ALU   = 3'b000;
    localparam logic [2:0] WB_MEM   = 3'b001;
    localparam logic [2:0] WB_AUIPC = 3'b010;
    localparam logic [2:0] WB_PC4   = 3'b011;
    localparam logic [2:0] WB_IMM   = 3'b111;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_ITYPE  = 2'b01;
    localparam logic [1:0] ALU_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_BRANCH = 2'b11;

    typedef struct packed {
        logic [1:0] jump_sel;
        logic       branch;
        logic       mem_rd;
        logic       mem_wr;
        logic       alu_src;
        logic       reg_we;
        logic [2:0] memto_reg;
        logic [1:0] alu_op;
        logic       muldiv;
        logic       illegal;
    } ctrl_t;

    function automatic logic is_wait_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM) || (s == ST_MULDIV);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Opcode-to-control mapping, purely combinational.
// Latency: 0 cycles; no backpressure (the FSM registers the result in DECODE).
module ctrl_decode
    import control_fsm_pkg::*;
(
    input  logic [4:0] opcode,
    input  logic       funct7_0,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (opcode)
            OPC_LOAD: begin
                ctrl.mem_rd    = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_we    = 1'b1;
                ctrl.memto_reg = WB_MEM;
                ctrl.alu_op    = ALU_ADD;
            end
            OPC_STORE: begin
                ctrl.mem_wr  = 1'b1;
                ctrl.alu_src = 1'b1;
                ctrl.alu_op  = ALU_ADD;
            end
            OPC_BRANCH: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_BRANCH;
            end
            OPC_OP: begin
                ctrl.reg_we    = 1'b1;
                ctrl.memto_reg = WB_ALU;
                ctrl.alu_op    = ALU_RTYPE;
                ctrl.muldiv    = funct7_0;
            end
            OPC_OP_IMM: begin
                ctrl.reg_we  = 1'b1;
                ctrl.alu_src = 1'b1;
                ctrl.alu_op  = ALU_ITYPE;
            end
            OPC_AUIPC: begin
                ctrl.reg_we    = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.memto_reg = WB_AUIPC;
            end
            OPC_LUI: begin
                ctrl.reg_we    = 1'b1;
                ctrl.memto_reg = WB_IMM;
            end
            OPC_JAL: begin
                ctrl.reg_we    = 1'b1;
                ctrl.jump_sel  = JMP_JAL;
                ctrl.memto_reg = WB_PC4;
            end
            OPC_JALR: begin
                ctrl.reg_we    = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.jump_sel  = JMP_JALR;
                ctrl.memto_reg = WB_PC4;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB) with memory wait timeout and sticky fault.
// Latency: 3-5 cycles per instruction with zero-wait memory; stalls on mem_ready (and muldiv_done).
// Optional MULDIV_EN macro adds a MULDIV wait state with muldiv_start/muldiv_done ports.
module control_fsm
    import control_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 15,
    parameter int ILLEGAL_TRAP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    output logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic [1:0]  jump_sel,
    output logic        branch,
    output logic        memRead,
    output logic        memWrite,
    output logic        ALUsrc,
    output logic        regWrite,
    output logic [2:0]  memtoReg,
    output logic [1:0]  ALUop,
    output logic [2:0]  state,
`ifdef MULDIV_EN
    input  logic        muldiv_done,
    output logic        muldiv_start,
`endif
    output logic        fault
);

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    state_t     cur_state, next_state;
    ctrl_t      dec, ctrl_q;
    logic [7:0] wait_cnt;
    logic       fault_q;
    logic       wait_done;
    logic       timed_out;
    logic       md_bit;

`ifdef MULDIV_EN
    assign md_bit    = inst[25];
    assign wait_done = (cur_state == ST_MULDIV) ? muldiv_done : mem_ready;
    logic unused_inst;
    assign unused_inst = ^{inst[31:26], inst[24:7], inst[1:0]};
`else
    assign md_bit    = 1'b0;
    assign wait_done = mem_ready;
    logic unused_inst;
    assign unused_inst = ^{inst[31:7], inst[1:0], ctrl_q.muldiv};
`endif

    assign timed_out = !wait_done && (wait_cnt == TIMEOUT);

    ctrl_decode u_decode (
        .opcode   (inst[6:2]),
        .funct7_0 (md_bit),
        .ctrl     (dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur_state <= ST_FETCH;
        else        cur_state <= next_state;
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            ST_FETCH: begin
                if (mem_ready)      next_state = ST_DECODE;
                else if (timed_out) next_state = ST_FAULT;
            end
            ST_DECODE: begin
                if (dec.illegal && (ILLEGAL_TRAP != 0)) next_state = ST_FAULT;
                else                                    next_state = ST_EXEC;
            end
            ST_EXEC: begin
                if (ctrl_q.mem_rd || ctrl_q.mem_wr)          next_state = ST_MEM;
                else if (ctrl_q.branch || ctrl_q.illegal)    next_state = ST_FETCH;
`ifdef MULDIV_EN
                else if (ctrl_q.muldiv)                      next_state = ST_MULDIV;
`endif
                else                                         next_state = ST_WB;
            end
            ST_MEM: begin
                if (mem_ready)      next_state = ctrl_q.mem_rd ? ST_WB : ST_FETCH;
                else if (timed_out) next_state = ST_FAULT;
            end
`ifdef MULDIV_EN
            ST_MULDIV: begin
                if (muldiv_done)    next_state = ST_WB;
                else if (timed_out) next_state = ST_FAULT;
            end
`endif
            ST_WB:    next_state = ST_FETCH;
            ST_FAULT: next_state = ST_FAULT;
            default:  next_state = ST_FAULT;
        endcase
    end

    // Controls are captured in DECODE and held until the instruction retires or faults.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q   <= '0;
            wait_cnt <= '0;
            fault_q  <= 1'b0;
        end else begin
            if (next_state == ST_FETCH || next_state == ST_FAULT) ctrl_q <= '0;
            else if (cur_state == ST_DECODE)                       ctrl_q <= dec;

            if (next_state != cur_state && is_wait_state(next_state)) wait_cnt <= '0;
            else if (is_wait_state(cur_state) && !wait_done && !timed_out)
                wait_cnt <= wait_cnt + 8'd1;

            if (next_state == ST_FAULT) fault_q <= 1'b1;
        end
    end

    // Gating with rst_n keeps every output low while reset is held, including the
    // state-decoded strobes that would otherwise reflect the reset FETCH state.
    always_comb begin
        mem_req  = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        regWrite = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        jump_sel = '0;
        branch   = 1'b0;
        ALUsrc   = 1'b0;
        memtoReg = '0;
        ALUop    = '0;
        state    = '0;
        fault    = 1'b0;
`ifdef MULDIV_EN
        muldiv_start = 1'b0;
`endif
        if (rst_n) begin
            state    = cur_state;
            fault    = fault_q;
            jump_sel = ctrl_q.jump_sel;
            branch   = ctrl_q.branch;
            ALUsrc   = ctrl_q.alu_src;
            memtoReg = ctrl_q.memto_reg;
            ALUop    = ctrl_q.alu_op;
            mem_req  = (cur_state == ST_FETCH) || (cur_state == ST_MEM);
            ir_write = (cur_state == ST_FETCH) && mem_ready;
            memRead  = (cur_state == ST_MEM) && ctrl_q.mem_rd;
            memWrite = (cur_state == ST_MEM) && ctrl_q.mem_wr;
            regWrite = (cur_state == ST_WB) && ctrl_q.reg_we;
            pc_write = ((cur_state == ST_FETCH) && mem_ready)
                     || ((cur_state == ST_EXEC) && ctrl_q.branch)
                     || ((cur_state == ST_WB) && (ctrl_q.jump_sel != JMP_NONE));
`ifdef MULDIV_EN
            // The counter is zero only in the first MULDIV cycle.
            muldiv_start = (cur_state == ST_MULDIV) && (wait_cnt == 8'd0);
`endif
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Directed self-checking bench for control_fsm: default-parameter DUT plus an ILLEGAL_TRAP=0 copy.
module tb_control_fsm;

    localparam logic [31:0] I_ADD = 32'h00B5_0533;
    localparam logic [31:0] I_LW  = 32'h0005_2583;
    localparam logic [31:0] I_SW  = 32'h00B5_2023;
    localparam logic [31:0] I_BEQ = 32'h00B5_0463;
    localparam logic [31:0] I_JAL = 32'h0080_00EF;
    localparam logic [31:0] I_ILL = 32'h0000_007F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst = '0;
    logic        mem_ready = 1'b0;

    logic       mem_req, pc_write, ir_write, branch, memRead, memWrite, ALUsrc, regWrite, fault;
    logic [1:0] jump_sel, ALUop;
    logic [2:0] memtoReg, state;

    logic       mem_req_b, pc_write_b, ir_write_b, branch_b, memRead_b, memWrite_b;
    logic       ALUsrc_b, regWrite_b, fault_b;
    logic [1:0] jump_sel_b, ALUop_b;
    logic [2:0] memtoReg_b, state_b;

    int checks = 0;
    int failures = 0;

    control_fsm dut (
        .clk(clk), .rst_n(rst_n), .inst(inst), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .jump_sel(jump_sel), .branch(branch),
        .memRead(memRead), .memWrite(memWrite), .ALUsrc(ALUsrc), .regWrite(regWrite),
        .memtoReg(memtoReg), .ALUop(ALUop), .state(state), .fault(fault)
    );

    control_fsm #(.MEM_TIMEOUT(15), .ILLEGAL_TRAP(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .inst(inst), .mem_req(mem_req_b), .mem_ready(mem_ready),
        .pc_write(pc_write_b), .ir_write(ir_write_b), .jump_sel(jump_sel_b), .branch(branch_b),
        .memRead(memRead_b), .memWrite(memWrite_b), .ALUsrc(ALUsrc_b), .regWrite(regWrite_b),
        .memtoReg(memtoReg_b), .ALUop(ALUop_b), .state(state_b), .fault(fault_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset: everything low even though mem_ready is high.
        mem_ready = 1'b1;
        inst = I_ADD;
        tick();
        chk("rst_state", state, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_ir_write", ir_write, 0);
        chk("rst_pc_write", pc_write, 0);
        chk("rst_regwrite", regWrite, 0);
        chk("rst_fault", fault, 0);
        rst_n = 1'b1;
        #1;

        // ADD, zero-wait: 0,1,2,4,0
        chk("add_f_state", state, 0);
        chk("add_f_mem_req", mem_req, 1);
        chk("add_f_ir_write", ir_write, 1);
        chk("add_f_pc_write", pc_write, 1);
        tick();
        chk("add_d_state", state, 1);
        chk("add_d_regwrite", regWrite, 0);
        tick();
        chk("add_e_state", state, 2);
        chk("add_e_aluop", ALUop, 2'b10);
        chk("add_e_regwrite", regWrite, 0);
        tick();
        chk("add_w_state", state, 4);
        chk("add_w_regwrite", regWrite, 1);
        chk("add_w_aluop", ALUop, 2'b10);
        chk("add_w_pc_write", pc_write, 0);
        tick();
        chk("add_ret_state", state, 0);
        chk("add_ret_regwrite", regWrite, 0);

        // BEQ: 3 cycles, pc_write in EXEC
        inst = I_BEQ;
        tick();
        chk("beq_d_state", state, 1);
        tick();
        chk("beq_e_state", state, 2);
        chk("beq_e_pc_write", pc_write, 1);
        chk("beq_e_branch", branch, 1);
        chk("beq_e_aluop", ALUop, 2'b11);
        tick();
        chk("beq_ret_state", state, 0);
        chk("beq_ret_branch", branch, 0);

        // JAL: WB has regWrite, pc_write, jump_sel=01, memtoReg=011
        inst = I_JAL;
        tick();
        tick();
        chk("jal_e_state", state, 2);
        tick();
        chk("jal_w_state", state, 4);
        chk("jal_w_regwrite", regWrite, 1);
        chk("jal_w_pc_write", pc_write, 1);
        chk("jal_w_jump_sel", jump_sel, 2'b01);
        chk("jal_w_memtoreg", memtoReg, 3'b011);
        tick();
        chk("jal_ret_state", state, 0);

        // LW with three wait cycles in MEM
        inst = I_LW;
        tick();
        tick();
        chk("lw_e_state", state, 2);
        chk("lw_e_alusrc", ALUsrc, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            mem_ready = (i == 3);
            #1;
            chk($sformatf("lw_mem%0d_state", i), state, 3);
            chk($sformatf("lw_mem%0d_memread", i), memRead, 1);
            chk($sformatf("lw_mem%0d_mem_req", i), mem_req, 1);
        end
        tick();
        chk("lw_w_state", state, 4);
        chk("lw_w_memtoreg", memtoReg, 3'b001);
        chk("lw_w_regwrite", regWrite, 1);
        chk("lw_w_fault", fault, 0);
        tick();
        chk("lw_ret_state", state, 0);

        // SW interrupted by reset while in MEM
        inst = I_SW;
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        chk("sw_m_state", state, 3);
        chk("sw_m_memwrite", memWrite, 1);
        chk("sw_m_regwrite", regWrite, 0);
        rst_n = 1'b0;
        #1;
        chk("sw_rst_memwrite", memWrite, 0);
        chk("sw_rst_mem_req", mem_req, 0);
        chk("sw_rst_state", state, 0);
        tick();
        chk("sw_rst_hold_memwrite", memWrite, 0);
        rst_n = 1'b1;
        #1;
        chk("sw_rel_state", state, 0);
        chk("sw_rel_fault", fault, 0);

        // Fetch timeout: 15 low cycles tolerated, the 16th faults
        for (int i = 0; i < 15; i++) tick();
        chk("to_pre_state", state, 0);
        chk("to_pre_fault", fault, 0);
        tick();
        chk("to_state", state, 7);
        chk("to_fault", fault, 1);
        chk("to_mem_req", mem_req, 0);
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("to_hold_state", state, 7);
        chk("to_hold_fault", fault, 1);
        chk("to_hold_pc_write", pc_write, 0);

        // Ready arriving exactly when the count hits MEM_TIMEOUT still succeeds
        rst_n = 1'b0;
        mem_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        mem_ready = 1'b1;
        #1;
        chk("edge_ir_write", ir_write, 1);
        tick();
        chk("edge_state", state, 1);
        chk("edge_fault", fault, 0);

        // Illegal opcode 11111: trap vs NOP
        rst_n = 1'b0;
        tick();
        inst = I_ILL;
        mem_ready = 1'b1;
        rst_n = 1'b1;
        tick();
        chk("ill_d_state", state, 1);
        chk("ill_d_state_b", state_b, 1);
        tick();
        chk("ill_trap_state", state, 7);
        chk("ill_trap_fault", fault, 1);
        chk("ill_nop_state_b", state_b, 2);
        chk("ill_nop_regwrite_b", regWrite_b, 0);
        chk("ill_nop_pc_write_b", pc_write_b, 0);
        chk("ill_nop_memwrite_b", memWrite_b, 0);
        tick();
        chk("ill_trap_hold", state, 7);
        chk("ill_nop_ret_b", state_b, 0);
        chk("ill_nop_fault_b", fault_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum memory wait cycles before a fault; range 1..255.
REQ-002 Parameter ILLEGAL_TRAP, default 1: 1 means an unknown opcode enters FAULT, 0 means it is treated as a NOP.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 inst  input  32  instruction word, valid while ir_write is low after FETCH.
REQ-006 mem_req  output  1  memory request (fetch, load or store).
REQ-007 mem_ready  input  1  memory handshake completion.
REQ-008 pc_write, ir_write  output  1 each  PC and IR register enables.
REQ-009 jump_sel  output  2  00 none, 01 JAL, 10 JALR.
REQ-010 branch, memRead, memWrite, ALUsrc, regWrite  output  1 each  datapath controls.
REQ-011 memtoReg  output  3  000 ALU, 001 memory, 010 AUIPC, 011 PC+4, 111 immediate.
REQ-012 ALUop  output  2  00 add, 01 I-type, 10 R-type, 11 branch compare.
REQ-013 state  output  3  current state, for debug.
REQ-014 fault  output  1  sticky fault flag.

Function
REQ-015 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=7, and MULDIV=5 when the feature is enabled.
REQ-016 FETCH: mem_req=1; while mem_ready=1, ir_write=1 and pc_write=1 for one cycle, then go to DECODE.
REQ-017 DECODE: decode inst[6:2] into registered control outputs using the REQ-009..012 encodings; all outputs stay stable through EXEC, MEM and WB.
REQ-018 DECODE next state: an illegal opcode with ILLEGAL_TRAP=1 goes to FAULT, otherwise all opcodes go to EXEC.
REQ-019 EXEC next state: load/store go to MEM; R, I, AUIPC, LUI, JAL and JALR go to WB; branch returns to FETCH and asserts pc_write for one cycle.
REQ-020 MEM: mem_req=1, with memRead or memWrite set; mem_ready moves a load to WB and a store to FETCH.
REQ-021 WB: regWrite pulses for exactly one cycle; JAL and JALR also assert pc_write in that cycle; next state is FETCH.
REQ-022 An 8-bit wait counter SHALL clear on entry to FETCH or MEM and increment each cycle mem_ready is low.
REQ-023 When the wait counter reaches MEM_TIMEOUT with mem_ready still low, the FSM goes to FAULT.
REQ-024 If mem_ready rises in the same cycle the count equals MEM_TIMEOUT, the handshake succeeds and no fault is raised.
REQ-025 FAULT: fault=1, all enables 0; only reset leaves it.
REQ-026 regWrite, memWrite and pc_write SHALL never assert outside the states named above.
REQ-027 A fetch-to-retire cycle count with zero-wait memory: R/I/U/J = 4, branch = 3, store = 4, load = 5.

Reset
REQ-028 When rst_n=0, state=FETCH, every output is 0, the wait counter is 0 and fault is 0, all asynchronously.
REQ-029 Reset asserted mid-MEM drops mem_req in the same cycle, and no write strobe is produced.

Configuration
REQ-030 With MULDIV_EN defined, an opcode of 01100 with inst[25]=1 goes EXEC->MULDIV and waits for input muldiv_done (1 bit) before WB; output muldiv_start pulses on entry to MULDIV.
REQ-031 MULDIV waits are subject to the MEM_TIMEOUT counter.
REQ-032 Without MULDIV_EN, the ports muldiv_done and muldiv_start do not exist, and inst[25] is ignored.

Structure
REQ-033 A shared package SHALL hold the state encodings, opcode constants (inst[6:2] values), and the jump_sel, memtoReg and ALUop encodings.
REQ-034 One sub-module, ctrl_decode, SHALL hold the combinational opcode-to-control mapping; control_fsm registers its outputs.

Verification
REQ-035 ADD with mem_ready always 1 -> states 0,1,2,4,0; regWrite high only in cycle 4; ALUop=10.
REQ-036 LW with mem_ready delayed 3 cycles in MEM -> memRead=1 for 4 MEM cycles, then WB with memtoReg=001; no fault.
REQ-037 Fetch with mem_ready stuck at 0 and MEM_TIMEOUT=15 -> fault=1 after 15 wait cycles; state=7 is held.
REQ-038 Opcode 5'b11111 with ILLEGAL_TRAP=1 -> FAULT; with ILLEGAL_TRAP=0 -> back to FETCH with no writes.
REQ-039 JAL -> WB cycle has regWrite=1, pc_write=1, jump_sel=01, memtoReg=011.
REQ-040 rst_n dropped during a SW in MEM -> memWrite=0 immediately; after release state=0 and fault=0.
